// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: FSM state encoding, port indices and the
// ALUctl codes used by the surrounding core.
package alu_share_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam logic [6:0] ALU_CTL_AND = 7'h00;
    localparam logic [6:0] ALU_CTL_OR  = 7'h01;
    localparam logic [6:0] ALU_CTL_ADD = 7'h02;
    localparam logic [6:0] ALU_CTL_SUB = 7'h06;
    localparam logic [6:0] ALU_CTL_XOR = 7'h0c;
    localparam logic [6:0] ALU_CTL_BEQ = 7'h16;

endpackage

// File: rtl/alu_rr_arbiter2.sv
// Combinational two-way grant: fixed priority to port 0, or round-robin against the port
// that last completed a transaction.
module alu_rr_arbiter2
    import alu_share_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_idx
);

    always_comb begin
        grant_valid = valid0 | valid1;
        if (valid0 && valid1) begin
            grant_idx = FIXED_PRIORITY ? PORT0 : ~last_grant;
        end else begin
            grant_idx = valid1 ? PORT1 : PORT0;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters: accept, drive the
// ALU for one cycle, then hold the registered result until the granted port takes it.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned CTL_WIDTH      = 7,
    parameter int unsigned FIXED_PRIORITY = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [CTL_WIDTH-1:0]  req0_ctl,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [CTL_WIDTH-1:0]  req1_ctl,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_branch,
    output logic [CTL_WIDTH-1:0]  alu_ctl,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_branch
);

    state_e                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  grant_q, grant_d;
    logic [CTL_WIDTH-1:0]  ctl_q, ctl_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  branch_q, branch_d;

    logic grant_valid;
    logic grant_idx;

    alu_rr_arbiter2 #(
        .FIXED_PRIORITY (FIXED_PRIORITY != 0)
    ) u_arb (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        ctl_d        = ctl_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        branch_d     = branch_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        rsp0_valid   = 1'b0;
        rsp1_valid   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    grant_d = grant_idx;
                    state_d = StExec;
                    if (grant_idx == PORT0) begin
                        req0_ready = 1'b1;
                        ctl_d      = req0_ctl;
                        a_d        = req0_a;
                        b_d        = req0_b;
                    end else begin
                        req1_ready = 1'b1;
                        ctl_d      = req1_ctl;
                        a_d        = req1_a;
                        b_d        = req1_b;
                    end
                end
            end
            StExec: begin
                result_d = alu_out;
                branch_d = alu_branch;
                state_d  = StResp;
            end
            StResp: begin
                // Only the granted port's rsp_ready can retire the result.
                if (grant_q == PORT0) begin
                    rsp0_valid = 1'b1;
                    if (rsp0_ready) begin
                        state_d      = StIdle;
                        last_grant_d = PORT0;
                    end
                end else begin
                    rsp1_valid = 1'b1;
                    if (rsp1_ready) begin
                        state_d      = StIdle;
                        last_grant_d = PORT1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= PORT1;
            grant_q      <= PORT0;
            ctl_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            branch_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            ctl_q        <= ctl_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
            branch_q     <= branch_d;
        end
    end

    assign alu_ctl    = ctl_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp_result = result_q;
    assign rsp_branch = branch_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each driving its own behavioural ALU.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
    logic [6:0]  req0_ctl, req1_ctl;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;

    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_branch, alu_branch;
    logic [31:0] rsp_result, alu_a, alu_b, alu_out;
    logic [6:0]  alu_ctl;

    logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid;
    logic        fp_rsp_branch, fp_alu_branch;
    logic [31:0] fp_rsp_result, fp_alu_a, fp_alu_b, fp_alu_out;
    logic [6:0]  fp_alu_ctl;

    function automatic logic [32:0] alu_f(input logic [6:0] ctl, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        logic        br;
        r  = '0;
        br = 1'b0;
        case (ctl)
            ALU_CTL_ADD: r = a + b;
            ALU_CTL_SUB: r = a - b;
            ALU_CTL_AND: r = a & b;
            ALU_CTL_OR:  r = a | b;
            ALU_CTL_XOR: r = a ^ b;
            ALU_CTL_BEQ: begin r = a - b; br = (a == b); end
            default:     r = '0;
        endcase
        return {br, r};
    endfunction

    assign {alu_branch, alu_out}       = alu_f(alu_ctl, alu_a, alu_b);
    assign {fp_alu_branch, fp_alu_out} = alu_f(fp_alu_ctl, fp_alu_a, fp_alu_b);

    alu_share_arbiter #(.DATA_WIDTH(32), .CTL_WIDTH(7), .FIXED_PRIORITY(0)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctl(req0_ctl),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctl(req1_ctl),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_branch(rsp_branch),
        .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_branch(alu_branch)
    );

    alu_share_arbiter #(.DATA_WIDTH(32), .CTL_WIDTH(7), .FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_ctl(req0_ctl),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_ctl(req1_ctl),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(fp_rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(fp_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(fp_rsp_result), .rsp_branch(fp_rsp_branch),
        .alu_ctl(fp_alu_ctl), .alu_a(fp_alu_a), .alu_b(fp_alu_b),
        .alu_out(fp_alu_out), .alu_branch(fp_alu_branch)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_req(input logic port, input logic v, input logic [6:0] ctl,
                           input logic [31:0] a, input logic [31:0] b);
        if (port == PORT0) begin
            req0_valid = v; req0_ctl = ctl; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_ctl = ctl; req1_a = a; req1_b = b;
        end
    endtask

    typedef struct {
        logic        port;
        logic [6:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        br;
    } vec_t;

    // One isolated transaction; the other port's rsp_ready pulses first and must be ignored.
    task automatic run_single(input vec_t v);
        set_req(v.port, 1'b1, v.ctl, v.a, v.b);
        settle();
        chk1("accept_ready_own", v.port ? req1_ready : req0_ready, 1'b1);
        chk1("accept_ready_other", v.port ? req0_ready : req1_ready, 1'b0);
        tick();
        set_req(v.port, 1'b0, 7'h7f, 32'hdead_beef, 32'hdead_beef);
        settle();
        chk1("exec_no_rsp", rsp0_valid | rsp1_valid, 1'b0);
        chk32("exec_alu_a", alu_a, v.a);
        tick();
        if (v.port == PORT0) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        settle();
        chk1("rsp_valid_own", v.port ? rsp1_valid : rsp0_valid, 1'b1);
        chk1("rsp_valid_other", v.port ? rsp0_valid : rsp1_valid, 1'b0);
        chk32("rsp_result", rsp_result, v.res);
        chk1("rsp_branch", rsp_branch, v.br);
        tick();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        settle();
        chk1("rsp_held_wrong_ready", v.port ? rsp1_valid : rsp0_valid, 1'b1);
        chk32("rsp_result_held", rsp_result, v.res);
        if (v.port == PORT0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        settle();
        chk1("idle_after_rsp", rsp0_valid | rsp1_valid, 1'b0);
    endtask

    // Random-phase reference state
    logic        off_v[2];
    logic [6:0]  off_ctl[2];
    logic [31:0] off_a[2], off_b[2];
    logic        busy, exp_port, last_winner, winner;
    logic [32:0] exp_val;
    int          acc_cycle;

    initial begin
        vec_t vecs[$];
        vec_t v;
        logic ex0, ex1, rv;

        reset = 1'b1;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_ctl = '0; req1_ctl = '0; req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        tick();
        tick();
        reset = 1'b0;
        settle();
        chk1("reset_req_ready", req0_ready | req1_ready, 1'b0);
        chk1("reset_rsp_valid", rsp0_valid | rsp1_valid, 1'b0);
        chk32("reset_result", rsp_result, 32'h0);
        chk1("reset_branch", rsp_branch, 1'b0);
        chk32("reset_alu_a", alu_a, 32'h0);

        vecs.push_back('{PORT0, ALU_CTL_ADD, 32'd5, 32'd7, 32'd12, 1'b0});
        vecs.push_back('{PORT1, ALU_CTL_BEQ, 32'd9, 32'd9, 32'd0, 1'b1});
        vecs.push_back('{PORT0, ALU_CTL_SUB, 32'd3, 32'd5, 32'hffff_fffe, 1'b0});
        vecs.push_back('{PORT1, ALU_CTL_AND, 32'hf0f0_1234, 32'h0ff0_ff00, 32'h00f0_1200, 1'b0});
        vecs.push_back('{PORT0, ALU_CTL_OR, 32'h1200_0034, 32'h0000_5600, 32'h1200_5634, 1'b0});
        vecs.push_back('{PORT1, ALU_CTL_XOR, 32'haaaa_5555, 32'hffff_0000, 32'h5555_5555, 1'b0});
        vecs.push_back('{PORT0, ALU_CTL_BEQ, 32'd1, 32'd2, 32'hffff_ffff, 1'b0});
        foreach (vecs[i]) run_single(vecs[i]);

        // Both ports saturate: RR alternates every 3 cycles, fixed priority keeps port 0.
        do_reset();
        set_req(PORT0, 1'b1, ALU_CTL_ADD, 32'd1, 32'd1);
        set_req(PORT1, 1'b1, ALU_CTL_ADD, 32'd2, 32'd2);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            settle();
            chk1("rr_req0_ready", req0_ready, (c % 6) == 0);
            chk1("rr_req1_ready", req1_ready, (c % 6) == 3);
            chk1("rr_rsp0_valid", rsp0_valid, (c % 6) == 2);
            chk1("rr_rsp1_valid", rsp1_valid, (c % 6) == 5);
            if ((c % 6) == 2) chk32("rr_result0", rsp_result, 32'd2);
            if ((c % 6) == 5) chk32("rr_result1", rsp_result, 32'd4);
            chk1("fp_req0_ready", fp_req0_ready, (c % 3) == 0);
            chk1("fp_req1_ready", fp_req1_ready, 1'b0);
            chk1("fp_rsp1_valid", fp_rsp1_valid, 1'b0);
            if ((c % 3) == 2) chk32("fp_result", fp_rsp_result, 32'd2);
            tick();
        end
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        do_reset();

        // Backpressure on port 0 with port 1 waiting.
        set_req(PORT0, 1'b1, ALU_CTL_ADD, 32'd10, 32'd20);
        set_req(PORT1, 1'b1, ALU_CTL_ADD, 32'd100, 32'd1);
        settle();
        chk1("bp_ready0", req0_ready, 1'b1);
        chk1("bp_ready1", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            settle();
            chk1("bp_rsp0_valid", rsp0_valid, 1'b1);
            chk32("bp_result", rsp_result, 32'd30);
            chk1("bp_no_ready", req0_ready | req1_ready, 1'b0);
            tick();
        end
        rsp0_ready = 1'b1;
        settle();
        chk1("bp_rsp0_final", rsp0_valid, 1'b1);
        tick();
        rsp0_ready = 1'b0;
        settle();
        chk1("bp_then_ready1", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        tick();
        rsp1_ready = 1'b1;
        settle();
        chk1("bp_rsp1_valid", rsp1_valid, 1'b1);
        chk32("bp_result1", rsp_result, 32'd101);
        tick();
        rsp1_ready = 1'b0;

        // Reset in EXEC after port 0 completed last: result cleared, next tie goes to port 0.
        v = '{PORT0, ALU_CTL_ADD, 32'd4, 32'd4, 32'd8, 1'b0};
        run_single(v);
        set_req(PORT1, 1'b1, ALU_CTL_ADD, 32'd3, 32'd4);
        settle();
        chk1("rx_ready1", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk1("rx_no_rsp", rsp0_valid | rsp1_valid, 1'b0);
            chk32("rx_result", rsp_result, 32'd0);
            tick();
        end
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        settle();
        chk1("rx_tie_port0", req0_ready, 1'b1);
        chk1("rx_tie_not1", req1_ready, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        do_reset();

        // Randomized traffic against a transaction-level model.
        busy = 1'b0; exp_port = 1'b0; last_winner = 1'b1; exp_val = '0; acc_cycle = 0;
        for (int p = 0; p < 2; p++) begin
            off_v[p] = 1'b0; off_ctl[p] = '0; off_a[p] = '0; off_b[p] = '0;
        end
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!off_v[p] && ($urandom % 3) == 0) begin
                    off_v[p] = 1'b1;
                    case ($urandom % 6)
                        0: off_ctl[p] = ALU_CTL_ADD;
                        1: off_ctl[p] = ALU_CTL_SUB;
                        2: off_ctl[p] = ALU_CTL_AND;
                        3: off_ctl[p] = ALU_CTL_OR;
                        4: off_ctl[p] = ALU_CTL_XOR;
                        default: off_ctl[p] = ALU_CTL_BEQ;
                    endcase
                    off_a[p] = $urandom;
                    off_b[p] = (($urandom % 4) == 0) ? off_a[p] : $urandom;
                end else if (off_v[p] && ($urandom % 12) == 0) begin
                    off_v[p] = 1'b0;
                end
                set_req(p[0], off_v[p], off_ctl[p], off_a[p], off_b[p]);
            end
            rsp0_ready = ($urandom % 2) == 0;
            rsp1_ready = ($urandom % 2) == 0;
            settle();

            ex0 = 1'b0; ex1 = 1'b0;
            if (!busy && (off_v[0] || off_v[1])) begin
                if (off_v[0] && off_v[1]) winner = ~last_winner;
                else winner = off_v[1];
                ex0 = (winner == 1'b0);
                ex1 = (winner == 1'b1);
            end
            chk1("rnd_req0_ready", req0_ready, ex0);
            chk1("rnd_req1_ready", req1_ready, ex1);

            rv = busy && (c - acc_cycle >= 2);
            chk1("rnd_rsp0_valid", rsp0_valid, rv && exp_port == 1'b0);
            chk1("rnd_rsp1_valid", rsp1_valid, rv && exp_port == 1'b1);
            if (rv) begin
                chk32("rnd_result", rsp_result, exp_val[31:0]);
                chk1("rnd_branch", rsp_branch, exp_val[32]);
                if (exp_port ? rsp1_ready : rsp0_ready) begin
                    busy = 1'b0;
                    last_winner = exp_port;
                end
            end else if (ex0 || ex1) begin
                busy      = 1'b1;
                exp_port  = ex1;
                exp_val   = alu_f(off_ctl[ex1], off_a[ex1], off_b[ex1]);
                acc_cycle = c;
                off_v[ex1] = 1'b0;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one combinational alu instance between two requesters (port 0: pipeline execute stage; port 1: CSR/auxiliary unit) using valid/ready handshakes.
- Arbitrates, latches operands, drives the ALU for one cycle, and captures ALUOut and Branch_Enable into a result register.
- Holds the registered result until the granted requester accepts it.
- Sits beside the alu in sail-core; the alu itself is instantiated outside this block.

Parameters:
DATA_WIDTH, 32, operand/result width.
CTL_WIDTH, 7, ALUctl width.
FIXED_PRIORITY, 0, 0 = round-robin between ports; 1 = port 0 always wins.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
req0_valid  input  1  port 0 request pending.
req0_ready  output  1  port 0 request accepted this cycle.
req0_ctl  input  CTL_WIDTH  port 0 ALUctl.
req0_a  input  DATA_WIDTH  port 0 operand A.
req0_b  input  DATA_WIDTH  port 0 operand B.
req1_valid, req1_ready, req1_ctl, req1_a, req1_b  as port 0, for port 1.
rsp0_valid  output  1  result ready for port 0.
rsp0_ready  input  1  port 0 consumes result.
rsp1_valid  output  1  result ready for port 1.
rsp1_ready  input  1  port 1 consumes result.
rsp_result  output  DATA_WIDTH  registered ALUOut, shared by both ports.
rsp_branch  output  1  registered Branch_Enable, shared by both ports.
alu_ctl  output  CTL_WIDTH  to alu ALUctl.
alu_a  output  DATA_WIDTH  to alu A.
alu_b  output  DATA_WIDTH  to alu B.
alu_out  input  DATA_WIDTH  from alu ALUOut.
alu_branch  input  1  from alu Branch_Enable.

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - state=IDLE; last_grant=1, so port 0 wins the first tie.
  - All ready/valid outputs 0; rsp_result=0; rsp_branch=0; operand regs (alu_ctl/a/b)=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is computed combinationally from req*_valid.
  - reqN_ready=1 only in IDLE, only for the granted N.
  - On grant, latch ctl/a/b into the operand regs, record grant, go to EXEC.
  - No valid requests: stay in IDLE.
- EXEC:
  - Operand regs drive alu_ctl/a/b; the ALU settles combinationally.
  - At the clock edge, rsp_result<=alu_out and rsp_branch<=alu_branch; go to RESP.
- RESP:
  - rspN_valid=1 for the granted N only; rsp_result/rsp_branch held stable.
  - On rspN_ready, go to IDLE and set last_grant<=N.
  - The other port's rsp_ready is ignored.
- Arbitration:
  - FIXED_PRIORITY=1: port 0 wins whenever valid.
  - FIXED_PRIORITY=0, both valid: grant the port != last_grant.
  - FIXED_PRIORITY=0, one valid: grant that port.
- Latency: request accepted at cycle t gives rspN_valid at t+2; earliest next accept at t+3 if rsp_ready is high at t+2.
- Throughput: one operation per 3 cycles minimum.
- Non-granted requester: its ready stays 0 and it must hold valid and operands stable; inputs are sampled only on its accept cycle.
- Operand regs keep their last value outside EXEC (no spurious ALU toggling required, no zeroing).
- rsp0_valid and rsp1_valid are never both 1. reqN_ready is never 1 outside IDLE.
- Reset asserted in EXEC or RESP discards the in-flight result; no response is produced.
- A requester dropping valid before it is accepted is legal; nothing is latched.

Decomposition:
- Add state encodings (IDLE/EXEC/RESP, 2 bits) and port indices to sail-core-defines alongside the ALUctl constants.
- Sub-module alu_rr_arbiter2: combinational 2-way grant from (valid0, valid1, last_grant, FIXED_PRIORITY) producing grant_valid and grant_idx.
- The FSM, operand registers and result registers stay in alu_share_arbiter.

Test Plan:
- Reset then single request: req0 ADD a=5 b=7 at t -> req0_ready=1 at t; rsp0_valid=1 at t+2 with rsp_result=12, rsp_branch=0; rsp1_valid stays 0.
- Branch path: req1 ctl=BEQ/SUB a=9 b=9 -> rsp1_valid at t+2, rsp_result=0, rsp_branch=1.
- Round-robin: both valid continuously with rsp_ready=1, FIXED_PRIORITY=0 -> grants alternate 0,1,0,1; each accept 3 cycles apart.
- Fixed priority: FIXED_PRIORITY=1, both valid continuously -> port 0 always granted; req1_ready stays 0.
- Backpressure: rsp0_ready=0 for 5 cycles after rsp0_valid -> rsp_result stable, req*_ready=0 throughout; accept completes on the rsp0_ready=1 cycle, then IDLE.
- Reset in EXEC: assert reset for 1 cycle in EXEC -> next cycle all valids 0, rsp_result=0, state IDLE; a subsequent tie goes to port 0.
